hpm_counter_bank: RTL and testbench

//  Bank of NUM_CNT free-running 64-bit event counters with an inhibit bit per channel.

---
 rtl/hpm_counter_bank_pkg.sv | 24 ++
 rtl/hpm_counter_bank_if.sv | 21 ++
 rtl/hpm_counter_bank_ch.sv | 39 +++
 rtl/hpm_counter_bank.sv | 107 ++++++++++
 tb/tb_hpm_counter_bank.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/hpm_counter_bank_pkg.sv
// Shared constants for the performance-counter bank: register word map and CTRL field layout.
package hpm_pkg;

  localparam int WORD_W       = 32;
  localparam int CTRL_INH_OFS = 0;
  localparam int CTRL_EN_OFS  = 16;

  function automatic int cnt_lo_addr(input int i);
    return 2 * i;
  endfunction

  function automatic int cnt_hi_addr(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int ctrl_addr(input int num_cnt);
    return 2 * num_cnt;
  endfunction

  function automatic int ovf_addr(input int num_cnt);
    return 2 * num_cnt + 1;
  endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// Single-cycle register access port: strobe/write/address/data in, registered read data + valid out.
interface hpm_counter_bank_if #(
  parameter int ADDR_W = 4
);
  logic              reg_en;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              reg_rvalid;

  modport master (
    output reg_en, reg_wr, reg_addr, reg_wdata,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_en, reg_wr, reg_addr, reg_wdata,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/hpm_counter_bank_ch.sv
// One counter channel: CNT_W-bit counter with lo/hi word write merge and wrap detect.
// A register write to either word pre-empts that cycle's increment (and its wrap).
module hpm_counter_ch
  import hpm_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inc_en_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ovf_set_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    ovf_set_o = 1'b0;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[WORD_W-1:0]     = wdata_i;
      if (wr_hi_i) cnt_d[CNT_W-1:WORD_W] = wdata_i[CNT_W-WORD_W-1:0];
    end else if (inc_en_i) begin
      cnt_d     = cnt_q + CNT_W'(1);
      ovf_set_o = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Performance-counter bank: per-channel 64-bit counters, CTRL (inhibit/ovf enable), W1C overflow status,
// shared hi-word shadow for atomic 64-bit reads, registered read port with one-cycle latency.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  hpm_counter_bank_if.slave  bus,
  input  logic [NUM_CNT-1:0] hw_stop,
  input  logic [NUM_CNT-1:0] event_inc,
  output logic               ovf_irq
);

  localparam int HI_W = CNT_W - WORD_W;

  logic               rd_en, wr_en;
  logic               ctrl_wr, ovf_wr;
  logic [NUM_CNT-1:0] wr_lo, wr_hi, inc_en, ovf_set;
  logic [CNT_W-1:0]   cnt [NUM_CNT];

  logic [NUM_CNT-1:0] sw_inhibit_q, ovf_en_q, ovf_sts_q, ovf_sts_d;
  logic [HI_W-1:0]    hi_shadow_q, hi_shadow_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d, ctrl_word;
  logic               rvalid_q;

  assign rd_en   = bus.reg_en & ~bus.reg_wr;
  assign wr_en   = bus.reg_en &  bus.reg_wr;
  assign ctrl_wr = wr_en && (bus.reg_addr == ADDR_W'(ctrl_addr(NUM_CNT)));
  assign ovf_wr  = wr_en && (bus.reg_addr == ADDR_W'(ovf_addr(NUM_CNT)));

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    assign wr_lo[i]  = wr_en && (bus.reg_addr == ADDR_W'(cnt_lo_addr(i)));
    assign wr_hi[i]  = wr_en && (bus.reg_addr == ADDR_W'(cnt_hi_addr(i)));
    assign inc_en[i] = event_inc[i] & ~hw_stop[i] & ~sw_inhibit_q[i];

    hpm_counter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .inc_en_i  (inc_en[i]),
      .wr_lo_i   (wr_lo[i]),
      .wr_hi_i   (wr_hi[i]),
      .wdata_i   (bus.reg_wdata),
      .cnt_o     (cnt[i]),
      .ovf_set_o (ovf_set[i])
    );
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_INH_OFS +: NUM_CNT] = sw_inhibit_q;
    ctrl_word[CTRL_EN_OFS  +: NUM_CNT] = ovf_en_q;
  end

  // A wrap in the same cycle as a W1C clear must survive, so the set is OR-ed in last.
  always_comb begin
    ovf_sts_d = ovf_sts_q;
    if (ovf_wr) ovf_sts_d = ovf_sts_q & ~bus.reg_wdata[NUM_CNT-1:0];
    ovf_sts_d = ovf_sts_d | ovf_set;
  end

  // Lo read snapshots the live upper bits; hi read returns that snapshot, never the live counter.
  always_comb begin
    rdata_d     = rdata_q;
    hi_shadow_d = hi_shadow_q;
    if (rd_en) begin
      rdata_d = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (bus.reg_addr == ADDR_W'(cnt_lo_addr(i))) begin
          rdata_d     = cnt[i][WORD_W-1:0];
          hi_shadow_d = cnt[i][CNT_W-1:WORD_W];
        end
        if (bus.reg_addr == ADDR_W'(cnt_hi_addr(i))) rdata_d = WORD_W'(hi_shadow_q);
      end
      if (bus.reg_addr == ADDR_W'(ctrl_addr(NUM_CNT))) rdata_d = ctrl_word;
      if (bus.reg_addr == ADDR_W'(ovf_addr(NUM_CNT)))  rdata_d = WORD_W'(ovf_sts_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_inhibit_q <= '0;
      ovf_en_q     <= '0;
      ovf_sts_q    <= '0;
      hi_shadow_q  <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        sw_inhibit_q <= bus.reg_wdata[CTRL_INH_OFS +: NUM_CNT];
        ovf_en_q     <= bus.reg_wdata[CTRL_EN_OFS  +: NUM_CNT];
      end
      ovf_sts_q   <= ovf_sts_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rd_en;
    end
  end

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;
  assign ovf_irq        = |(ovf_sts_q & ovf_en_q);

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank (NUM_CNT=4, CNT_W=64): hand-computed expectations at each step.
module tb_hpm_counter_bank;

  localparam int NUM_CNT = 4;
  localparam int ADDR_W  = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NUM_CNT-1:0] hw_stop = '0;
  logic [NUM_CNT-1:0] event_inc = '0;
  logic               ovf_irq;

  int errors = 0;
  int checks = 0;

  hpm_counter_bank_if #(.ADDR_W(ADDR_W)) bus ();

  hpm_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(64), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .hw_stop   (hw_stop),
    .event_inc (event_inc),
    .ovf_irq   (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.reg_en = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(posedge clk); #1;
    bus.reg_en = 1'b0; bus.reg_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    bus.reg_en = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = a;
    @(posedge clk); #1;
    bus.reg_en = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, bus.reg_rvalid}, 32'd1);
    chk(tag, bus.reg_rdata, exp);
  endtask

  initial begin
    bus.reg_en = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_rdata",  bus.reg_rdata, 32'd0);
    chk("rst_rvalid", {31'd0, bus.reg_rvalid}, 32'd0);
    chk("rst_irq",    {31'd0, ovf_irq}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: ten increments on channel 0
    event_inc = 4'b0001;
    repeat (10) @(posedge clk); #1;
    event_inc = '0;
    rd("t1_cnt0_lo", 4'd0, 32'd10);
    rd("t1_cnt0_hi", 4'd1, 32'd0);
    rd("t1_cnt1_lo", 4'd2, 32'd0);
    rd("t1_cnt3_lo", 4'd6, 32'd0);
    @(posedge clk); #1;
    chk("t1_rvalid_idle", {31'd0, bus.reg_rvalid}, 32'd0);
    chk("t1_rdata_hold",  bus.reg_rdata, 32'd0);

    // 2: wrap on channel 1 with ovf_en[1]
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'hFFFF_FFFF);
    wr(4'd8, 32'h0002_0000);
    rd("t2_ctrl", 4'd8, 32'h0002_0000);
    event_inc = 4'b0010;
    @(posedge clk); #1;
    event_inc = '0;
    chk("t2_irq_set", {31'd0, ovf_irq}, 32'd1);
    rd("t2_cnt1_lo", 4'd2, 32'd0);
    rd("t2_cnt1_hi", 4'd3, 32'd0);
    rd("t2_ovf_sts", 4'd9, 32'h2);
    wr(4'd9, 32'h2);
    chk("t2_irq_clr", {31'd0, ovf_irq}, 32'd0);
    rd("t2_ovf_clr", 4'd9, 32'h0);

    // 3: hw_stop, then sw_inhibit on channel 2
    hw_stop = 4'b0100; event_inc = 4'b0100;
    repeat (5) @(posedge clk); #1;
    hw_stop = '0;
    repeat (3) @(posedge clk); #1;
    event_inc = '0;
    rd("t3_hwstop_cnt2", 4'd4, 32'd3);
    wr(4'd8, 32'h0000_0004);
    event_inc = 4'b0100;
    repeat (5) @(posedge clk); #1;
    event_inc = '0;
    rd("t3_inh_cnt2", 4'd4, 32'd3);
    wr(4'd8, 32'h0);
    event_inc = 4'b0100;
    repeat (2) @(posedge clk); #1;
    event_inc = '0;
    rd("t3_resume_cnt2", 4'd4, 32'd5);

    // 4: atomic 64-bit read through the hi shadow
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd1, 32'h0);
    rd("t4_lo", 4'd0, 32'hFFFF_FFFF);
    event_inc = 4'b0001;
    repeat (3) @(posedge clk); #1;
    event_inc = '0;
    rd("t4_hi_shadow", 4'd1, 32'd0);
    rd("t4_lo2", 4'd0, 32'd2);
    rd("t4_hi2", 4'd1, 32'd1);
    wr(4'd2, 32'h1234);
    chk("t4_rdata_hold_wr", bus.reg_rdata, 32'd1);

    // 5: write beats increment; set beats W1C
    bus.reg_en = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 4'd6; bus.reg_wdata = 32'h55;
    event_inc = 4'b1000;
    @(posedge clk); #1;
    bus.reg_en = 1'b0; bus.reg_wr = 1'b0; event_inc = '0;
    rd("t5_cnt3_lo", 4'd6, 32'h55);
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'hFFFF_FFFF);
    bus.reg_en = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 4'd9; bus.reg_wdata = 32'h2;
    event_inc = 4'b0010;
    @(posedge clk); #1;
    bus.reg_en = 1'b0; bus.reg_wr = 1'b0; event_inc = '0;
    rd("t5_ovf_set_wins", 4'd9, 32'h2);
    chk("t5_irq_masked", {31'd0, ovf_irq}, 32'd0);
    wr(4'd8, 32'h0002_0000);
    chk("t5_irq_enabled", {31'd0, ovf_irq}, 32'd1);

    // 6: unmapped read, then reset mid-access
    rd("t6_unmapped", 4'd10, 32'd0);
    event_inc = 4'b1111;
    @(posedge clk); #1;
    bus.reg_en = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = 4'd6;
    #2 rstn = 1'b0;
    @(posedge clk); #1;
    bus.reg_en = 1'b0; event_inc = '0;
    chk("t6_rst_rvalid", {31'd0, bus.reg_rvalid}, 32'd0);
    chk("t6_rst_rdata",  bus.reg_rdata, 32'd0);
    chk("t6_rst_irq",    {31'd0, ovf_irq}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 2 * NUM_CNT + 2; a++) begin
      rd($sformatf("t6_post_rst_a%0d", a), ADDR_W'(a), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
